// File: rtl/cam_ctrl_if.sv
// Request/response handshake bundle between a dictionary client and cam_ctrl.
// The master side issues byte lookups; the slave side (cam_ctrl) answers them.
interface cam_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       req_alloc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic       rsp_new;
  logic       rsp_err;
  logic [4:0] rsp_idx;

  modport master (
    output req_valid, req_data, req_alloc, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_new, rsp_err, rsp_idx
  );

  modport slave (
    input  req_valid, req_data, req_alloc, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_new, rsp_err, rsp_idx
  );
endinterface

// File: rtl/cam_ctrl.sv
// Lookup-or-insert sequencer for a 16x8 CAM: fills the CAM after reset, then
// serves one byte request at a time and allocates missing bytes round-robin.
module cam_ctrl #(
  parameter int         NB_MEM    = 16,
  parameter int         SIZE_ADDR = 4,
  parameter logic [7:0] INIT_VAL  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  cam_ctrl_if.slave  bus,
  output logic       init_done_o,
  output logic       cam_enable_o,
  output logic       cam_write_o,
  output logic [4:0] cam_addr_o,
  output logic [7:0] cam_data_o,
  input  logic [4:0] cam_out_i,
  input  logic       cam_found_i
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SEARCH,
    EVAL,
    ALLOC,
    RESP
  } state_t;

  localparam logic [SIZE_ADDR-1:0] LAST_IDX  = SIZE_ADDR'(NB_MEM - 1);
  localparam logic [SIZE_ADDR:0]   FULL_CNT  = (SIZE_ADDR + 1)'(NB_MEM);

  state_t               state_q, state_d;
  logic [SIZE_ADDR-1:0] init_ptr_q, init_ptr_d;
  logic [SIZE_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE_ADDR:0]   count_q, count_d;
  logic [7:0]           data_q, data_d;
  logic                 alloc_q, alloc_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic                 rsp_new_q, rsp_new_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [4:0]           rsp_idx_q, rsp_idx_d;
  logic                 init_done_q, init_done_d;

  logic                 cam_en, cam_wr;
  logic [4:0]           cam_addr;
  logic [7:0]           cam_data;
  logic                 req_ready, rsp_valid;
  logic                 hit;

  // Only entries below count have been allocated; anything above still holds INIT_VAL.
  assign hit = cam_found_i && (cam_out_i < 5'(count_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      alloc_q     <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_new_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      alloc_q     <= alloc_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_new_q   <= rsp_new_d;
      rsp_err_q   <= rsp_err_d;
      rsp_idx_q   <= rsp_idx_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    alloc_d     = alloc_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_new_d   = rsp_new_q;
    rsp_err_d   = rsp_err_q;
    rsp_idx_d   = rsp_idx_q;
    init_done_d = init_done_q;
    cam_en      = 1'b0;
    cam_wr      = 1'b0;
    cam_addr    = '0;
    cam_data    = '0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      INIT: begin
        cam_wr     = 1'b1;
        cam_addr   = 5'(init_ptr_q);
        cam_data   = INIT_VAL;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) begin
          init_ptr_d  = '0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end

      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          data_d    = bus.req_data;
          alloc_d   = bus.req_alloc;
          rsp_hit_d = 1'b0;
          rsp_new_d = 1'b0;
          rsp_idx_d = '0;
          if (bus.req_data == INIT_VAL) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = SEARCH;
          end
        end
      end

      SEARCH: begin
        cam_en   = 1'b1;
        cam_data = data_q;
        state_d  = EVAL;
      end

      EVAL: begin
        if (hit) begin
          rsp_hit_d = 1'b1;
          rsp_idx_d = cam_out_i;
          state_d   = RESP;
        end else if (alloc_q) begin
          state_d = ALLOC;
        end else begin
          state_d = RESP;
        end
      end

      // Round-robin insert: once full, the oldest slot is the next one overwritten.
      ALLOC: begin
        cam_wr    = 1'b1;
        cam_addr  = 5'(wr_ptr_q);
        cam_data  = data_q;
        rsp_new_d = 1'b1;
        rsp_idx_d = 5'(wr_ptr_q);
        wr_ptr_d  = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        if (count_q != FULL_CNT) begin
          count_d = count_q + 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // The reset state is INIT, so decoded outputs are masked while reset is held.
  assign cam_enable_o  = rst_n & cam_en;
  assign cam_write_o   = rst_n & cam_wr;
  assign cam_addr_o    = rst_n ? cam_addr : 5'd0;
  assign cam_data_o    = rst_n ? cam_data : 8'd0;
  assign bus.req_ready = rst_n & req_ready;
  assign bus.rsp_valid = rst_n & rsp_valid;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_new   = rsp_new_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign init_done_o   = init_done_q;

  a_en_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(cam_enable_o && cam_write_o));

  a_addr_msb_zero: assert property (@(posedge clk) disable iff (!rst_n)
    cam_addr_o[4] == 1'b0);

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed, table-driven bench for cam_ctrl with a behavioural 16x8 CAM model
// (registered found/out, highest matching index wins).
module tb_cam_ctrl;
  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic       cam_enable;
  logic       cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  cam_ctrl_if bus();

  cam_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .init_done_o  (init_done),
    .cam_enable_o (cam_enable),
    .cam_write_o  (cam_write),
    .cam_addr_o   (cam_addr),
    .cam_data_o   (cam_data),
    .cam_out_i    (cam_out),
    .cam_found_i  (cam_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] camMem [16];
  logic       matchFound;
  logic [4:0] matchIdx;

  always_comb begin
    matchFound = 1'b0;
    matchIdx   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (camMem[i] == cam_data) begin
        matchFound = 1'b1;
        matchIdx   = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cam_write) begin
      camMem[cam_addr[3:0]] <= cam_data;
    end else if (cam_enable) begin
      cam_found <= matchFound;
      cam_out   <= matchIdx;
    end
  end

  int bothHigh = 0;
  always @(negedge clk) begin
    if (cam_enable && cam_write) bothHigh++;
  end

  typedef struct {
    logic [7:0] data;
    logic       alloc;
    logic       expHit;
    logic       expNew;
    logic       expErr;
    logic [4:0] expIdx;
    int         expLat;
    int         expEn;
    int         expWr;
  } vec_t;

  vec_t vecs [26];
  int   passCount  = 0;
  int   checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic setVec(input int i, input logic [7:0] d, input logic a, input logic h,
                        input logic n, input logic e, input logic [4:0] idx,
                        input int lat, input int en, input int wr);
    vecs[i].data   = d;
    vecs[i].alloc  = a;
    vecs[i].expHit = h;
    vecs[i].expNew = n;
    vecs[i].expErr = e;
    vecs[i].expIdx = idx;
    vecs[i].expLat = lat;
    vecs[i].expEn  = en;
    vecs[i].expWr  = wr;
  endtask

  function automatic logic [25:0] allOutputs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_new, bus.rsp_err,
            bus.rsp_idx, init_done, cam_enable, cam_write, cam_addr, cam_data};
  endfunction

  task automatic waitReady(input string name);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at a negedge right after rst_n is released.
  task automatic checkInit(input string name);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput($sformatf("%s_cycle%0d", name, i),
                  {cam_write, cam_enable, cam_addr, cam_data, bus.req_ready, init_done},
                  {1'b1, 1'b0, 5'(i), 8'hFF, 1'b0, 1'b0});
      @(negedge clk);
    end
    checkOutput({name, "_done"}, {cam_write, cam_enable, bus.req_ready, init_done}, 4'b0011);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int lat = 0;
    int en  = 0;
    int wr  = 0;
    waitReady(name);
    bus.req_valid = 1'b1;
    bus.req_data  = v.data;
    bus.req_alloc = v.alloc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (cam_enable) en++;
      if (cam_write) wr++;
    end while (!bus.rsp_valid && lat < 20);
    checkOutput({name, "_valid"}, bus.rsp_valid, 1'b1);
    checkOutput({name, "_fields"}, {bus.rsp_hit, bus.rsp_new, bus.rsp_err, bus.rsp_idx},
                {v.expHit, v.expNew, v.expErr, v.expIdx});
    checkOutput({name, "_latency"}, lat, v.expLat);
    checkOutput({name, "_cam_en_wr"}, {en[15:0], wr[15:0]}, {v.expEn[15:0], v.expWr[15:0]});
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    setVec(0, 8'h3C, 1, 0, 1, 0, 5'd0, 4, 1, 1);
    setVec(1, 8'h3C, 1, 1, 0, 0, 5'd0, 3, 1, 0);
    setVec(2, 8'h55, 0, 0, 0, 0, 5'd0, 3, 1, 0);
    setVec(3, 8'hFF, 1, 0, 0, 1, 5'd0, 1, 0, 0);
    setVec(4, 8'hA5, 0, 0, 0, 0, 5'd0, 3, 1, 0);
    setVec(5, 8'h3C, 0, 0, 0, 0, 5'd0, 3, 1, 0);
    for (int i = 0; i < 16; i++) setVec(6 + i, 8'(i), 1, 0, 1, 0, 5'(i), 4, 1, 1);
    setVec(22, 8'h99, 1, 0, 1, 0, 5'd0, 4, 1, 1);
    setVec(23, 8'h00, 0, 0, 0, 0, 5'd0, 3, 1, 0);
    setVec(24, 8'h0F, 0, 1, 0, 0, 5'd15, 3, 1, 0);
    setVec(25, 8'h99, 0, 1, 0, 0, 5'd0, 3, 1, 0);

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_alloc = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 26'd0);
    rst_n = 1'b1;
    checkInit("init");

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    waitReady("hold");
    bus.req_valid = 1'b1;
    bus.req_data  = 8'hFF;
    bus.req_alloc = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold_cycle%0d", k),
                  {bus.rsp_valid, bus.rsp_err, bus.rsp_hit, bus.rsp_new, bus.rsp_idx,
                   bus.req_ready, cam_enable, cam_write},
                  {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("hold_released", {bus.rsp_valid, bus.req_ready}, 2'b01);

    waitReady("rst_alloc");
    bus.req_valid = 1'b1;
    bus.req_data  = 8'hA5;
    bus.req_alloc = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cam_write && n < 10);
    checkOutput("rst_alloc_reached", {cam_write, cam_data}, {1'b1, 8'hA5});
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_alloc_outputs", allOutputs(), 26'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkInit("reinit");

    for (int i = 4; i < 26; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    checkOutput("en_wr_exclusive", bothHigh, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
